// File: rtl/mem_resp_pkg.sv
// Shared constants, status layout and address decode for the mem_responder slice.
package mem_resp_pkg;

    localparam logic [31:0] CON_ADDR_DEF   = 32'h8000_0000;
    localparam int unsigned ST_FULL        = 0;
    localparam int unsigned ST_EMPTY       = 1;
    localparam int unsigned ST_COUNT_LO    = 4;
    localparam int unsigned ST_COUNT_HI    = 7;
    localparam logic [31:0] UNMAPPED_RDATA = 32'd0;

    typedef enum logic [1:0] {RG_RAM, RG_CON, RG_NONE} region_e;

    // RAM occupies the bottom 2^(addr_w+2) bytes; the console is a single exact address.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input int unsigned addr_w,
                                              input logic [31:0] con_addr);
        if ((addr >> (addr_w + 32'd2)) == 32'd0) return RG_RAM;
        if (addr == con_addr) return RG_CON;
        return RG_NONE;
    endfunction

endpackage

// File: rtl/resp_con_fifo.sv
// Console byte FIFO: wrap-bit pointers, no fall-through, push accepted on full when popping.
module resp_con_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    output logic                     full,
    input  logic                     pop,
    output logic                     valid,
    output logic [W-1:0]             data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid   = (wr_ptr != rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign data    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Dual-port memory responder: byte-enable RAM, console MMIO FIFO, 1-cycle registered reads.
// Optional macro RESP_WRITE_FIRST_EN: same-cycle reads of a written word return merged new data.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter logic [31:0] CON_ADDR  = CON_ADDR_DEF,
    parameter int unsigned CON_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_add1,
    input  logic [3:0]  mem_wen1,
    input  logic [31:0] mem_wdata1,
    output logic [31:0] mem_rdata1,
    input  logic [31:0] mem_add2,
    input  logic [3:0]  mem_wen2,
    input  logic [31:0] mem_wdata2,
    output logic [31:0] mem_rdata2,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        con_ovf,
    output logic        bad_acc
);

    localparam int unsigned WORDS = 1 << ADDR_W;
    localparam int unsigned CW    = $clog2(CON_DEPTH) + 1;

    logic [1:0]        rst_sync;
    logic              rst_n;
    region_e           rg1;
    region_e           rg2;
    logic [ADDR_W-1:0] idx1;
    logic [ADDR_W-1:0] idx2;
    logic [3:0]        wr1;
    logic [3:0]        wr2;
    logic [31:0]       ram [WORDS];
    logic [31:0]       rd1;
    logic [31:0]       rd2;
    logic [31:0]       con_status;
    logic              push_req;
    logic              pop;
    logic              fifo_full;
    logic              fifo_valid;
    logic [7:0]        fifo_data;
    logic [CW-1:0]     fifo_count;

    // Asynchronous assert, two-flop synchronised release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign rg1      = decode_region(mem_add1, ADDR_W, CON_ADDR);
    assign rg2      = decode_region(mem_add2, ADDR_W, CON_ADDR);
    assign idx1     = mem_add1[ADDR_W+1:2];
    assign idx2     = mem_add2[ADDR_W+1:2];
    assign wr1      = (rg1 == RG_RAM) ? mem_wen1 : 4'b0000;
    assign wr2      = (rg2 == RG_RAM) ? mem_wen2 : 4'b0000;
    assign push_req = (rg2 == RG_CON) && mem_wen2[0];
    assign pop      = fifo_valid && con_ready;

    // Later assignment wins, so port 2 owns colliding lanes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr1[i]) ram[idx1][8*i +: 8] <= mem_wdata1[8*i +: 8];
            if (wr2[i]) ram[idx2][8*i +: 8] <= mem_wdata2[8*i +: 8];
        end
    end

    always_comb begin
        rd1 = ram[idx1];
        rd2 = ram[idx2];
`ifdef RESP_WRITE_FIRST_EN
        for (int i = 0; i < 4; i++) begin
            if (wr2[i] && (idx2 == idx1)) rd1[8*i +: 8] = mem_wdata2[8*i +: 8];
            else if (wr1[i])              rd1[8*i +: 8] = mem_wdata1[8*i +: 8];
            if (wr2[i])                   rd2[8*i +: 8] = mem_wdata2[8*i +: 8];
            else if (wr1[i] && (idx1 == idx2)) rd2[8*i +: 8] = mem_wdata1[8*i +: 8];
        end
`endif
    end

    always_comb begin
        con_status                          = '0;
        con_status[ST_FULL]                 = fifo_full;
        con_status[ST_EMPTY]                = !fifo_valid;
        con_status[ST_COUNT_HI:ST_COUNT_LO] = 4'(fifo_count);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata1 <= '0;
            mem_rdata2 <= '0;
            con_ovf    <= 1'b0;
            bad_acc    <= 1'b0;
        end else begin
            mem_rdata1 <= (rg1 == RG_RAM) ? rd1 : UNMAPPED_RDATA;
            case (rg2)
                RG_RAM:  mem_rdata2 <= rd2;
                RG_CON:  mem_rdata2 <= con_status;
                default: mem_rdata2 <= UNMAPPED_RDATA;
            endcase
            bad_acc <= (rg1 == RG_NONE) || (rg2 == RG_NONE);
            if (push_req && fifo_full && !pop) con_ovf <= 1'b1;
        end
    end

    resp_con_fifo #(
        .DEPTH (CON_DEPTH),
        .W     (8)
    ) u_con_fifo (
        .clk       (clk),
        .reset_n   (rst_n),
        .push      (push_req),
        .push_data (mem_wdata2[7:0]),
        .full      (fifo_full),
        .pop       (pop),
        .valid     (fifo_valid),
        .data      (fifo_data),
        .count     (fifo_count)
    );

    assign con_valid = fifo_valid;
    assign con_data  = fifo_data;

endmodule
